// File: rtl/axi_packet_gate_pkg.sv
// Shared constants for the store-and-forward packet gate.
package axi_packet_gate_pkg;

    // Output skid stage depth: one word being offered plus one landing from the RAM.
    localparam int unsigned SKID_DEPTH = 2;

    typedef logic [1:0] skid_cnt_t;

endpackage

// File: rtl/axi_packet_gate_ram_2port.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module ram_2port #(
    parameter int DW = 65,
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register only moves on a read, so it holds the last word fetched.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_packet_gate.sv
// Store-and-forward AXI-Stream gate: packets are released only once fully buffered and
// error-free. Both ports use valid/ready: a beat transfers on a rising edge where valid & ready.
module axi_packet_gate
    import axi_packet_gate_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SIZE  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    input  logic             i_tlast,
    input  logic             i_terror,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    output logic             o_tlast,
    input  logic             o_tready
);

    localparam int PW = SIZE + 1;

    logic [SIZE:0]  wr_ptr_q, wr_ptr_d;
    logic [SIZE:0]  commit_ptr_q, commit_ptr_d;
    logic [SIZE:0]  rd_ptr_q, rd_ptr_d;
    logic           rd_vld_q;
    skid_cnt_t      skid_cnt_q, skid_cnt_d, skid_kept;
    logic [WIDTH:0] skid0_q, skid0_d, skid1_q, skid1_d;
    logic [WIDTH:0] ram_rdata;
    logic [SIZE:0]  occupancy;
    logic [2:0]     skid_level;
    logic           full, in_fire, out_fire, has_committed, rd_en;

    // Occupancy counts every written word not yet fetched, committed or not.
    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign full          = (occupancy == {1'b1, {SIZE{1'b0}}});
    assign i_tready      = ~full;
    assign in_fire       = i_tvalid & i_tready;
    assign has_committed = (commit_ptr_q != rd_ptr_q);

    assign o_tvalid = (skid_cnt_q != '0);
    assign out_fire = o_tvalid & o_tready;
    assign o_tdata  = skid0_q[WIDTH-1:0];
    assign o_tlast  = o_tvalid & skid0_q[WIDTH];

    // Fetch only if the word is guaranteed a skid slot once it lands next cycle.
    assign skid_level = {1'b0, skid_cnt_q} + {2'b0, rd_vld_q} - {2'b0, out_fire};
    assign rd_en      = has_committed & (skid_level < 3'(SKID_DEPTH));

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (in_fire) begin
            if (i_tlast && i_terror) begin
                wr_ptr_d = commit_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (i_tlast) begin
                    commit_ptr_d = wr_ptr_q + PW'(1);
                end
            end
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_kept  = skid_cnt_q - {1'b0, out_fire};
        skid_cnt_d = skid_kept + {1'b0, rd_vld_q};
        if (out_fire) begin
            skid0_d = skid1_q;
        end
        if (rd_vld_q) begin
            if (skid_kept == '0) begin
                skid0_d = ram_rdata;
            end else begin
                skid1_d = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_vld_q     <= 1'b0;
            skid_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_vld_q     <= rd_en;
            skid_cnt_q   <= skid_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        skid0_q <= skid0_d;
        skid1_q <= skid1_d;
    end

    ram_2port #(
        .DW(WIDTH + 1),
        .AW(SIZE)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (in_fire),
        .waddr_i(wr_ptr_q[SIZE-1:0]),
        .wdata_i({i_tlast, i_tdata}),
        .re_i   (rd_en),
        .raddr_i(rd_ptr_q[SIZE-1:0]),
        .rdata_o(ram_rdata)
    );

endmodule

// File: tb/tb_axi_packet_gate.sv
// Directed bench for axi_packet_gate with a 64-word buffer and 32-bit data.
module tb_axi_packet_gate;

    localparam int W = 32;
    localparam int S = 6;

    logic         clk = 1'b0;
    logic         reset, clear;
    logic [W-1:0] i_tdata, o_tdata;
    logic         i_tvalid, i_tlast, i_terror, i_tready;
    logic         o_tvalid, o_tlast, o_tready;

    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] exp_q[$];

    int   rd_mode = 0;       // 0: o_tready low, 1: always high, 2: random
    bit   watch_gap = 0;
    bit   seen_first = 0;
    int   gap_cnt = 0;
    bit   prev_stall = 0;
    logic [W:0] prev_word;

    typedef struct {
        logic [W-1:0] base;
        int           len;
        logic         err_last;
        logic         err_mid;
        logic         keep;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    axi_packet_gate #(.WIDTH(W), .SIZE(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .i_tdata (i_tdata),
        .i_tvalid(i_tvalid),
        .i_tlast (i_tlast),
        .i_terror(i_terror),
        .i_tready(i_tready),
        .o_tdata (o_tdata),
        .o_tvalid(o_tvalid),
        .o_tlast (o_tlast),
        .o_tready(o_tready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready pattern, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rd_mode)
            0:       o_tready = 1'b0;
            1:       o_tready = 1'b1;
            default: o_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard and hold/gap monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [W:0] e;
        if (prev_stall) begin
            n_checks++;
            if (!o_tvalid || ({o_tlast, o_tdata} !== prev_word)) begin
                n_errors++;
                $display("FAIL hold: got v=%0b %0h expected v=1 %0h", o_tvalid, {o_tlast, o_tdata}, prev_word);
            end
        end
        if (o_tvalid && o_tready && !reset && !clear) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out: got %0h expected none", {o_tlast, o_tdata});
            end else begin
                e = exp_q.pop_front();
                if ({o_tlast, o_tdata} !== e) begin
                    n_errors++;
                    $display("FAIL out_word: got %0h expected %0h", {o_tlast, o_tdata}, e);
                end
            end
        end
        if (watch_gap) begin
            if (o_tvalid) seen_first = 1;
            else if (seen_first && exp_q.size() > 0) gap_cnt++;
        end
        prev_stall = o_tvalid && !o_tready && !reset && !clear;
        prev_word  = {o_tlast, o_tdata};
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts and ends at 1 ns after a rising edge, so consecutive calls stream back-to-back.
    task automatic push(input logic [W-1:0] d, input logic last, input logic err, output int stalls);
        bit done;
        done     = 0;
        stalls   = 0;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = last;
        i_terror = err;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (i_tready) begin
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got no i_tready expected accept of %0h", d);
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_terror = 1'b0;
    endtask

    task automatic push_packet(input logic [W-1:0] base, input int len, input logic err_last,
                               input logic err_mid, input logic keep, output int stalls);
        int st;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            push(base + W'(i), i == len - 1, (i == len - 1) ? err_last : err_mid, st);
            stalls += st;
        end
        if (keep) begin
            for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, base + W'(i)});
        end
    endtask

    task automatic drain(input string name, input int bound);
        for (int t = 0; t < bound; t++) begin
            if (exp_q.size() == 0) break;
            idle(1);
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        idle(4);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 900000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, stalls;
        reset    = 1'b1;
        clear    = 1'b0;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_terror = 1'b0;
        i_tdata  = '0;
        o_tready = 1'b0;

        vecs[0] = '{base: 0,   len: 16, err_last: 0, err_mid: 0, keep: 1};
        vecs[1] = '{base: 16,  len: 16, err_last: 1, err_mid: 0, keep: 0};
        vecs[2] = '{base: 32,  len: 16, err_last: 0, err_mid: 0, keep: 1};
        vecs[3] = '{base: 100, len: 1,  err_last: 0, err_mid: 0, keep: 1};
        vecs[4] = '{base: 200, len: 1,  err_last: 1, err_mid: 0, keep: 0};
        vecs[5] = '{base: 300, len: 8,  err_last: 0, err_mid: 1, keep: 1};
        vecs[6] = '{base: 400, len: 64, err_last: 0, err_mid: 0, keep: 1};
        vecs[7] = '{base: 500, len: 3,  err_last: 1, err_mid: 1, keep: 0};

        // Reset held for about 100 ns
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_o_tvalid", o_tvalid, 0);
        check("reset_o_tlast", o_tlast, 0);
        check("reset_i_tready", i_tready, 1);

        // Fill to exactly 64 words with the output blocked
        rd_mode = 0;
        idle(1);
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            push(W'(i), i == 63, 1'b0, st);
            stalls += st;
        end
        check("fill_stalls", stalls, 0);
        check("full_i_tready", i_tready, 0);
        for (int i = 0; i < 64; i++) exp_q.push_back({i == 63, W'(i)});
        idle(2);
        check("commit_latency_o_tvalid", o_tvalid, 1);
        check("full_release_i_tready", i_tready, 1);
        rd_mode = 1;
        drain("drain_fill", 500);

        // Ten back-to-back 32-word packets with continuous draining
        watch_gap  = 1;
        seen_first = 0;
        gap_cnt    = 0;
        stalls     = 0;
        for (int p = 0; p < 10; p++) begin
            push_packet(W'(p * 32), 32, 1'b0, 1'b0, 1'b1, st);
            stalls += st;
        end
        drain("drain_btb", 500);
        watch_gap = 0;
        check("btb_stalls", stalls, 0);
        check("btb_o_tvalid_gaps", gap_cnt, 0);

        // Table of packets including dropped ones
        for (int v = 0; v < 8; v++) begin
            push_packet(vecs[v].base, vecs[v].len, vecs[v].err_last, vecs[v].err_mid, vecs[v].keep, st);
        end
        drain("drain_table", 1000);

        // Random gaps on both sides, words 1..1600, tlast every 16th
        rd_mode = 2;
        for (int k = 1; k <= 1600; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 16));
            push(W'(k), (k % 16) == 0, 1'b0, st);
            if ((k % 16) == 0) begin
                for (int j = k - 15; j <= k; j++) exp_q.push_back({j == k, W'(j)});
            end
        end
        drain("drain_random", 20000);

        // Clear in the middle of a packet
        rd_mode = 1;
        for (int i = 0; i < 5; i++) push(W'(32'hA0 + i), 1'b0, 1'b0, st);
        pulse_clear();
        check("clear_mid_o_tvalid", o_tvalid, 0);
        check("clear_mid_i_tready", i_tready, 1);
        push_packet(W'(32'hB0), 4, 1'b0, 1'b0, 1'b1, st);
        drain("drain_clear_mid", 200);

        // Clear while a committed packet waits at the output
        rd_mode = 0;
        idle(1);
        push_packet(W'(32'hC0), 4, 1'b0, 1'b0, 1'b0, st);
        idle(3);
        check("pending_o_tvalid", o_tvalid, 1);
        check("pending_o_tdata", o_tdata, 32'hC0);
        pulse_clear();
        check("flush_o_tvalid", o_tvalid, 0);
        check("flush_o_tlast", o_tlast, 0);
        rd_mode = 1;
        idle(6);
        push_packet(W'(32'hD0), 2, 1'b0, 1'b0, 1'b1, st);
        drain("drain_after_flush", 200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
